// File: rtl/rijndael_inv_shiftrows_serial.sv
// rtl/rijndael_inv_shiftrows_serial.sv - byte-serial Rijndael InvShiftRows with valid/ready streams
module rijndael_inv_shiftrows_serial #(
   parameter int NB = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clear_i,
   input  logic [7:0] in_data_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   output logic [7:0] out_data_o,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic       out_last_o,
   output logic       busy_o
);

   localparam int NBYTES = 4 * NB;
   localparam int CW     = $clog2(NBYTES);
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("rijndael_inv_shiftrows_serial: NB must be 4, 6 or 8");
   end

   typedef enum logic {FILL, DRAIN} state_t;

   state_t        state;
   logic [CW-1:0] in_cnt;
   logic [CW-1:0] out_cnt;
   logic [7:0]    state_buf [NBYTES];
   logic [CW-1:0] src;

   // Buffer position holding output byte k: row j moves right by SHIFT[j] on
   // decryption, so the source column is (col - SHIFT[j]) mod NB.
   function automatic logic [CW-1:0] src_idx(input logic [CW-1:0] k);
      int col;
      int row;
      int sh;
      col = int'(k) / 4;
      row = int'(k) % 4;
      sh  = (NB == 8 && row >= 2) ? row + 1 : row;
      return CW'(4 * ((col - sh + NB) % NB) + row);
   endfunction

   // Fill/drain sequencer: counters, buffer writes and phase change.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= FILL;
         in_cnt  <= '0;
         out_cnt <= '0;
         for (int i = 0; i < NBYTES; i++) begin
            state_buf[i] <= 8'h00;
         end
      end else if (clear_i) begin
         state   <= FILL;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         case (state)
            FILL: begin
               if (in_valid_i) begin
                  state_buf[in_cnt] <= in_data_i;
                  if (in_cnt == LAST) begin
                     in_cnt <= '0;
                     state  <= DRAIN;
                  end else begin
                     in_cnt <= in_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (out_ready_i) begin
                  if (out_cnt == LAST) begin
                     out_cnt <= '0;
                     state   <= FILL;
                  end else begin
                     out_cnt <= out_cnt + 1'b1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // Output byte is read straight from the buffer through the inverse mapping.
   always_comb begin
      src = src_idx(out_cnt);
   end

   assign out_data_o  = state_buf[src];
   assign in_ready_o  = (state == FILL);
   assign out_valid_o = (state == DRAIN);
   assign busy_o      = (state == DRAIN);
   assign out_last_o  = (state == DRAIN) && (out_cnt == LAST);

endmodule

// File: tb/tb_rijndael_inv_shiftrows_serial.sv
// tb/tb_rijndael_inv_shiftrows_serial.sv - directed bench for rijndael_inv_shiftrows_serial
module tb_rijndael_inv_shiftrows_serial;

   typedef logic [7:0] bytes_t [32];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear     [3];
   logic [7:0] in_data   [3];
   logic       in_valid  [3];
   logic       in_ready  [3];
   logic [7:0] out_data  [3];
   logic       out_valid [3];
   logic       out_ready [3];
   logic       out_last  [3];
   logic       busy      [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rijndael_inv_shiftrows_serial #(.NB(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear[0]),
      .in_data_i(in_data[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
      .out_data_o(out_data[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
      .out_last_o(out_last[0]), .busy_o(busy[0]));

   rijndael_inv_shiftrows_serial #(.NB(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear[1]),
      .in_data_i(in_data[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
      .out_data_o(out_data[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
      .out_last_o(out_last[1]), .busy_o(busy[1]));

   rijndael_inv_shiftrows_serial #(.NB(6)) dut6 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear[2]),
      .in_data_i(in_data[2]), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
      .out_data_o(out_data[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
      .out_last_o(out_last[2]), .busy_o(busy[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: output byte k of InvShiftRows comes from input index returned here.
   function automatic int inv_src(input int nb, input int k);
      int i, j, sh;
      i  = k / 4;
      j  = k % 4;
      sh = (nb == 8 && j >= 2) ? j + 1 : j;
      return 4 * ((i - sh + nb) % nb) + j;
   endfunction

   function automatic int row_shift(input int nb, input int j);
      return (nb == 8 && j >= 2) ? j + 1 : j;
   endfunction

   task automatic fill(input int s, input int n, input bytes_t d, input bit gaps);
      int  k = 0;
      int  guard = 0;
      bit  first = 1'b1;
      while (k < n && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (first) check("fill_in_ready", in_ready[s], 1);
         first = 1'b0;
         check("fill_out_valid", out_valid[s], 0);
         in_valid[s] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data[s]  = in_valid[s] ? d[k] : 8'h5A;
         if (in_valid[s] && in_ready[s]) k++;
      end
      check("fill_count", k, n);
   endtask

   task automatic drain(input int s, input int n, input int stop, input bit rnd,
                        output bytes_t got);
      int         k = 0;
      int         guard = 0;
      bit         first = 1'b1;
      bit         stall = 1'b0;
      logic [7:0] pd = 8'h00;
      got = '{default: 8'h00};
      while (k < stop && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (first) check("first_out_valid", out_valid[s], 1);
         first = 1'b0;
         check("drain_in_ready", in_ready[s], 0);
         check("drain_busy", busy[s], 1);
         if (stall) begin
            check("hold_valid", out_valid[s], 1);
            check("hold_data", out_data[s], pd);
         end
         in_valid[s]  = 1'b1;
         in_data[s]   = 8'hEE;
         out_ready[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid[s]) begin
            check("out_last", out_last[s], (k == n - 1));
            if (out_ready[s]) begin
               got[k] = out_data[s];
               k++;
               stall = 1'b0;
               if (k == n) in_valid[s] = 1'b0;
            end else begin
               stall = 1'b1;
               pd    = out_data[s];
            end
         end
      end
      check("drain_count", k, stop);
   endtask

   bytes_t din, got;
   logic [7:0] exp4 [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                             8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
   logic [7:0] expc [16] = '{8'h10, 8'h1D, 8'h1A, 8'h17, 8'h14, 8'h11, 8'h1E, 8'h1B,
                             8'h18, 8'h15, 8'h12, 8'h1F, 8'h1C, 8'h19, 8'h16, 8'h13};
   logic [7:0] exp8 [4]  = '{8'h00, 8'h1D, 8'h16, 8'h13};

   initial begin
      for (int s = 0; s < 3; s++) begin
         clear[s] = 1'b0; in_data[s] = 8'h00; in_valid[s] = 1'b0; out_ready[s] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check("rst_in_ready", in_ready[s], 1);
         check("rst_out_valid", out_valid[s], 0);
         check("rst_out_last", out_last[s], 0);
         check("rst_busy", busy[s], 0);
         check("rst_out_data", out_data[s], 0);
      end
      rst_n = 1'b1;

      // NB=4 straight pass
      for (int k = 0; k < 32; k++) din[k] = 8'(k);
      fill(0, 16, din, 1'b0);
      drain(0, 16, 16, 1'b0, got);
      for (int k = 0; k < 16; k++) check($sformatf("nb4_out[%0d]", k), got[k], exp4[k]);

      // NB=8: hand values, model, and forward ShiftRows round trip
      fill(1, 32, din, 1'b0);
      drain(1, 32, 32, 1'b0, got);
      for (int k = 0; k < 4; k++) check($sformatf("nb8_head[%0d]", k), got[k], exp8[k]);
      for (int k = 0; k < 32; k++)
         check($sformatf("nb8_model[%0d]", k), got[k], din[inv_src(8, k)]);
      for (int k = 0; k < 32; k++)
         check($sformatf("nb8_fwd[%0d]", k),
               got[4 * (((k / 4) + row_shift(8, k % 4)) % 8) + (k % 4)], 8'(k));

      // NB=4 with input gaps and output backpressure
      fill(0, 16, din, 1'b1);
      drain(0, 16, 16, 1'b1, got);
      for (int k = 0; k < 16; k++) check($sformatf("bp_out[%0d]", k), got[k], exp4[k]);

      // clear after 7 bytes, then a fresh state 0x10..0x1F
      fill(0, 7, din, 1'b0);
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = 8'hC3; clear[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0; clear[0] = 1'b0;
      check("clr_in_ready", in_ready[0], 1);
      check("clr_out_valid", out_valid[0], 0);
      for (int k = 0; k < 16; k++) din[k] = 8'(k + 16);
      fill(0, 16, din, 1'b0);
      drain(0, 16, 16, 1'b0, got);
      for (int k = 0; k < 16; k++) check($sformatf("clr_out[%0d]", k), got[k], expc[k]);

      // async reset in DRAIN after 5 output bytes
      for (int k = 0; k < 16; k++) din[k] = 8'(k);
      fill(0, 16, din, 1'b0);
      drain(0, 16, 5, 1'b0, got);
      @(negedge clk);
      out_ready[0] = 1'b0; in_valid[0] = 1'b0;
      check("pre_rst_valid", out_valid[0], 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_out_valid", out_valid[0], 0);
      check("async_in_ready", in_ready[0], 1);
      check("async_out_data", out_data[0], 0);
      check("async_busy", busy[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_idle", out_valid[0], 0);
      end
      fill(0, 16, din, 1'b0);
      drain(0, 16, 16, 1'b0, got);
      for (int k = 0; k < 16; k++) check($sformatf("rst_out[%0d]", k), got[k], exp4[k]);

      // NB=6: three random states back to back
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < 24; k++) din[k] = 8'($urandom);
         fill(2, 24, din, 1'b0);
         drain(2, 24, 24, 1'b0, got);
         for (int k = 0; k < 24; k++)
            check($sformatf("nb6_s%0d[%0d]", t, k), got[k], din[inv_src(6, k)]);
      end
      @(negedge clk);
      check("nb6_final_ready", in_ready[2], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rijndael_inv_shiftrows_serial.md
Name: rijndael_inv_shiftrows_serial

Overview:
Byte-serial InvShiftRows engine for the Rijndael decryption path. It accepts one Rijndael state as a stream of 4*NB bytes and buffers the complete state. It then emits 4*NB bytes of the inverse-row-shifted state. Both sides use a valid/ready handshake, so the block can sit between byte-wide decryption stages, memories, or bus interfaces.

Parameters:
NB, 4, state width in 32-bit columns; legal values 4, 6, 8 (elaboration error otherwise).
NBYTES, 4*NB, localparam, bytes per state.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_ni  input  1  asynchronous active-low reset.
clear_i  input  1  synchronous abort: discard the buffer and return to FILL.
in_data_i  input  8  input state byte.
in_valid_i  input  1  in_data_i is valid.
in_ready_o  output  1  the block can accept a byte.
out_data_o  output  8  output state byte.
out_valid_o  output  1  out_data_o is valid.
out_ready_i  input  1  the consumer accepts the byte.
out_last_o  output  1  high with the final byte (index NBYTES-1) of the state.
busy_o  output  1  high while in DRAIN.

Behaviour:
- Byte order, both streams: column-major, byte k maps to column i = k/4, row j = k%4.
  - Byte 0 is the MSB byte of the flat state (the usual Rijndael order).
- Shift offsets SHIFT[j]:
  - {0,1,2,3} for NB=4 or 6.
  - {0,1,3,4} for NB=8.
- Transform: out[j][i] = in[j][(i - SHIFT[j] + NB) mod NB]. This is the exact inverse of the encryption ShiftRows.
- Storage: NBYTES x 8-bit register buffer, written in input order.
  - out_data_o is a mux of the buffer, indexed by the inverse mapping of the output counter.
  - No combinational path from in_* to out_*.
- Counters:
  - in_cnt and out_cnt, each clog2(NBYTES) bits wide.
  - Each wraps to 0 after reaching NBYTES-1.
- FSM states: FILL, DRAIN.
  - FILL:
    - in_ready_o=1, out_valid_o=0.
    - A transfer happens when in_valid_i && in_ready_o. It writes buf[in_cnt] and increments in_cnt.
    - On the transfer with in_cnt==NBYTES-1: in_cnt is set to 0 and the next state is DRAIN.
  - DRAIN:
    - in_ready_o=0, out_valid_o=1, busy_o=1.
    - out_data_o = buf[src(out_cnt)].
    - A transfer happens when out_valid_o && out_ready_i. It increments out_cnt.
    - On the transfer with out_cnt==NBYTES-1: out_cnt is set to 0 and the next state is FILL.
- out_last_o = DRAIN && out_cnt==NBYTES-1.
- Latency and throughput:
  - The first output byte is valid in the cycle after the last input byte is accepted.
  - One byte per cycle per side when not stalled.
  - One state per 2*NBYTES cycles minimum; the FILL and DRAIN phases do not overlap.
- Backpressure:
  - While out_ready_i=0, out_data_o, out_valid_o, out_last_o and out_cnt hold stable.
  - in_valid_i gaps in FILL only delay the transfer; the buffer and in_cnt hold.
- in_valid_i in DRAIN is ignored: nothing is written and no counter moves.
- clear_i has priority over any transfer in the same cycle:
  - next state FILL, in_cnt=0, out_cnt=0.
  - Buffer contents are don't-care; no reset of the buffer is needed.
- Reset (rst_ni=0, asynchronous): state FILL, in_cnt=0, out_cnt=0.
  - Outputs go immediately to in_ready_o=1, out_valid_o=0, out_last_o=0, busy_o=0, out_data_o=0.
  - The buffer is cleared to 0 on reset.
  - Reset mid-FILL or mid-DRAIN discards the partial state. No output beat is produced afterwards until a full new state is loaded.

Test Plan:
- NB=4, input bytes 0x00..0x0F, out_ready_i=1:
  - Required output: 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03.
  - out_last_o high only on 03.
  - First out_valid_o one cycle after byte 0x0F is accepted.
- NB=8, input bytes 0x00..0x1F:
  - First four outputs: 00 1D 16 13.
  - Full output matches the reference model for offsets {0,1,3,4}.
  - Feeding the output through the existing forward ShiftRows block returns 0x00..0x1F.
- Backpressure, NB=4:
  - Random out_ready_i and random in_valid_i gaps give a sequence identical to scenario 1.
  - out_data_o is stable while out_valid_o=1 and out_ready_i=0.
  - in_ready_o=0 throughout DRAIN.
- clear_i after 7 input bytes, then 16 new bytes 0x10..0x1F:
  - Output is the transform of 0x10..0x1F only: 10 1D 1A 17 14 11 1E 1B 18 15 12 1F 1C 19 16 13.
- Async reset asserted mid-DRAIN after 5 output bytes:
  - out_valid_o drops without waiting for a clock edge.
  - After reset release, a fresh 16-byte load produces a correct, complete 16-byte output.
- Back-to-back states, NB=6, 3 consecutive random states:
  - Each 24-byte output matches the model.
  - in_ready_o reasserts in the cycle after each out_last_o transfer.
